// File: rtl/ps2_kb_pkg.sv
// Shared PS/2 set-2 constants, event/decode types and the scan-code to hex-digit decoder.
package ps2_kb_pkg;

    localparam logic [7:0] SC_RELEASE = 8'hF0;

    localparam logic [7:0] SC_HEX_0 = 8'h45;
    localparam logic [7:0] SC_HEX_1 = 8'h16;
    localparam logic [7:0] SC_HEX_2 = 8'h1E;
    localparam logic [7:0] SC_HEX_3 = 8'h26;
    localparam logic [7:0] SC_HEX_4 = 8'h25;
    localparam logic [7:0] SC_HEX_5 = 8'h2E;
    localparam logic [7:0] SC_HEX_6 = 8'h36;
    localparam logic [7:0] SC_HEX_7 = 8'h3D;
    localparam logic [7:0] SC_HEX_8 = 8'h3E;
    localparam logic [7:0] SC_HEX_9 = 8'h46;
    localparam logic [7:0] SC_HEX_A = 8'h1C;
    localparam logic [7:0] SC_HEX_B = 8'h32;
    localparam logic [7:0] SC_HEX_C = 8'h21;
    localparam logic [7:0] SC_HEX_D = 8'h23;
    localparam logic [7:0] SC_HEX_E = 8'h24;
    localparam logic [7:0] SC_HEX_F = 8'h2B;

    typedef struct packed {
        logic       rel;
        logic [7:0] code;
    } kb_event_t;

    typedef struct packed {
        logic       is_hex;
        logic [3:0] hex;
    } hex_dec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } kb_state_t;

    function automatic hex_dec_t sc_to_hex(input logic [7:0] code);
        hex_dec_t r;
        r = '{is_hex: 1'b1, hex: 4'h0};
        case (code)
            SC_HEX_0: r.hex = 4'h0;
            SC_HEX_1: r.hex = 4'h1;
            SC_HEX_2: r.hex = 4'h2;
            SC_HEX_3: r.hex = 4'h3;
            SC_HEX_4: r.hex = 4'h4;
            SC_HEX_5: r.hex = 4'h5;
            SC_HEX_6: r.hex = 4'h6;
            SC_HEX_7: r.hex = 4'h7;
            SC_HEX_8: r.hex = 4'h8;
            SC_HEX_9: r.hex = 4'h9;
            SC_HEX_A: r.hex = 4'hA;
            SC_HEX_B: r.hex = 4'hB;
            SC_HEX_C: r.hex = 4'hC;
            SC_HEX_D: r.hex = 4'hD;
            SC_HEX_E: r.hex = 4'hE;
            SC_HEX_F: r.hex = 4'hF;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO with occupancy count; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 held-code to key-event queue: 2-FF sync, stability filter, press FSM, event FIFO, hex decode.
// Define KEY_RELEASE_EVENT_EN to also queue release events (FIFO widens to 9 bits).
module ps2_key_event_queue
    import ps2_kb_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     kb_code,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [7:0]                     evt_code,
    output logic                           evt_release,
    output logic                           evt_is_hex,
    output logic [3:0]                     evt_hex,
    output logic [$clog2(FIFO_DEPTH):0]    evt_count,
    output logic                           overflow,
    input  logic                           ovf_clr
);
    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
`ifdef KEY_RELEASE_EVENT_EN
    localparam int EVT_W = 9;
`else
    localparam int EVT_W = 8;
`endif

    logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    kb_state_t        state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             accept, push;
    logic [7:0]       push_code;
    logic [EVT_W-1:0] push_word, head_word;
    logic             fifo_full, fifo_empty;
    hex_dec_t         dec;
`ifdef KEY_RELEASE_EVENT_EN
    logic             pend_q, pend_d;
    logic             push_rel;
`endif

    always_comb begin
        sync1_d = kb_code;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        if (sync2_q != prev_q)     cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        // The equality guard stops a saturated count from accepting a value that only just changed.
        accept = (cnt_q == CNT_MAX) && (sync2_q == prev_q) && (sync2_q != acc_q);
        acc_d  = accept ? sync2_q : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_code = sync2_q;
`ifdef KEY_RELEASE_EVENT_EN
        push_rel  = 1'b0;
        pend_d    = 1'b0;
        // Second half of a direct key change: acc_q already holds the new code.
        if (pend_q) begin
            push      = 1'b1;
            push_code = acc_q;
        end
`endif
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q != '0) begin
                        push    = 1'b1;
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (sync2_q == '0) begin
                        state_d = ST_IDLE;
`ifdef KEY_RELEASE_EVENT_EN
                        push      = 1'b1;
                        push_code = acc_q;
                        push_rel  = 1'b1;
`endif
                    end else begin
`ifdef KEY_RELEASE_EVENT_EN
                        push      = 1'b1;
                        push_code = acc_q;
                        push_rel  = 1'b1;
                        pend_d    = 1'b1;
`else
                        push      = 1'b1;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr)                                  ovf_d = 1'b0;
        else if (push && fifo_full && !evt_ready)     ovf_d = 1'b1;
    end

    // NOTE: all state uses non-blocking assignments so each flop samples pre-edge values (no ordering races).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
`ifdef KEY_RELEASE_EVENT_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
`ifdef KEY_RELEASE_EVENT_EN
            pend_q  <= pend_d;
`endif
        end
    end

`ifdef KEY_RELEASE_EVENT_EN
    assign push_word   = {push_rel, push_code};
    assign evt_release = !fifo_empty && head_word[8];
`else
    assign push_word   = push_code;
    assign evt_release = 1'b0;
`endif

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_word),
        .pop     (evt_ready),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (evt_count)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = fifo_empty ? 8'h00 : head_word[7:0];
    assign dec        = sc_to_hex(evt_code);
    assign evt_is_hex = dec.is_hex;
    assign evt_hex    = dec.hex;
    assign overflow   = ovf_q;

endmodule
